// File: rtl/qdr_mport_arbiter.sv
// Multi-port round-robin front-end onto the QDR controller user command port; read data steered back by tag FIFO.
// Latency: grant combinational, usr_* command registered next cycle; read return registered one cycle after usr_rd_dvld.
// Backpressure: requests held until p_ack; reads stall while the tag FIFO is full; no grants outside RUN. Optional: QDR_MPORT_STATS_EN.
module qdr_mport_arbiter #(
  parameter int NUM_PORTS    = 2,
  parameter int ADDR_WIDTH   = 21,
  parameter int DATA_WIDTH   = 72,
  parameter int BE_WIDTH     = 8,
  parameter int TAG_DEPTH    = 16,
  parameter int DRAIN_CYCLES = 64
) (
  input  logic                             clk0,
  input  logic                             reset_n,
  input  logic                             phy_rdy,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  p_addr,
  input  logic [NUM_PORTS-1:0]             p_wr_req,
  input  logic [NUM_PORTS-1:0]             p_rd_req,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  p_wr_data,
  input  logic [NUM_PORTS*BE_WIDTH-1:0]    p_wr_be,
  output logic [NUM_PORTS-1:0]             p_ack,
  output logic                             p_ack_wr,
  output logic [DATA_WIDTH-1:0]            p_rd_data,
  output logic [NUM_PORTS-1:0]             p_rd_dvld,
  output logic [ADDR_WIDTH-1:0]            usr_addr,
  output logic                             usr_wr_strb,
  output logic [DATA_WIDTH-1:0]            usr_wr_data,
  output logic [BE_WIDTH-1:0]              usr_wr_be,
  output logic                             usr_rd_strb,
  input  logic [DATA_WIDTH-1:0]            usr_rd_data,
  input  logic                             usr_rd_dvld,
  output logic                             err_unexp_rd,
`ifdef QDR_MPORT_STATS_EN
  input  logic                             stat_clr,
  output logic [NUM_PORTS*32-1:0]          stat_wr_cnt,
  output logic [NUM_PORTS*32-1:0]          stat_rd_cnt,
`endif
  output logic                             err_flush
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int TW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW = $clog2(TAG_DEPTH + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {WAIT_PHY, RUN, DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [DW-1:0]           drain_cnt_q, drain_cnt_d;
  logic                    flush;
  logic [PW-1:0]           rr_ptr_q;
  logic [PW-1:0]           tag_mem_q [TAG_DEPTH];
  logic [TW-1:0]           wptr_q, rptr_q;
  logic [CW-1:0]           cnt_q;
  logic                    fifo_full, fifo_empty, push, pop;
  logic [NUM_PORTS-1:0]    elig;
  logic                    run_en, gnt_vld, gnt_wr;
  logic [PW-1:0]           gnt_idx;
  int                      idx;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic [BE_WIDTH-1:0]     sel_be;
  logic [ADDR_WIDTH-1:0]   usr_addr_q;
  logic [DATA_WIDTH-1:0]   usr_wr_data_q, p_rd_data_q;
  logic [BE_WIDTH-1:0]     usr_wr_be_q;
  logic                    usr_wr_strb_q, usr_rd_strb_q;
  logic [NUM_PORTS-1:0]    p_rd_dvld_q;
  logic                    err_unexp_rd_q, err_flush_q;

  assign fifo_full  = (cnt_q == CW'(TAG_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  // A read is only eligible while a tag slot is free; writes never wait on the FIFO.
  assign elig       = p_wr_req | (p_rd_req & {NUM_PORTS{~fifo_full}});
  // Gate on phy_rdy too so the cycle where the PHY drops issues nothing.
  assign run_en     = (state_q == RUN) && phy_rdy;
  assign push       = gnt_vld & ~gnt_wr;
  assign pop        = usr_rd_dvld & ~fifo_empty;

  // Round-robin search from the port after the last grant, plus port-data muxing.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    idx      = 0;
    sel_addr = '0;
    sel_data = '0;
    sel_be   = '0;
    p_ack    = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_PORTS;
      if (run_en && !gnt_vld && elig[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
    // Write wins when a port raises both; its read stays pending.
    gnt_wr = gnt_vld & p_wr_req[gnt_idx];
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt_idx == PW'(i)) begin
        sel_addr = p_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = p_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_be   = p_wr_be[i*BE_WIDTH +: BE_WIDTH];
      end
    end
    if (gnt_vld) p_ack[gnt_idx] = 1'b1;
  end

  assign p_ack_wr = gnt_wr;

  // Next-state logic: drain waits for in-flight reads, flushing on timeout.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    flush       = 1'b0;
    case (state_q)
      WAIT_PHY: if (phy_rdy) state_d = RUN;
      RUN: begin
        if (!phy_rdy) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          state_d = WAIT_PHY;
        end else if (drain_cnt_q == DW'(DRAIN_CYCLES)) begin
          flush   = 1'b1;
          state_d = WAIT_PHY;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      default: state_d = WAIT_PHY;
    endcase
  end

  // State register and drain counter.
  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= WAIT_PHY;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Registered command to the controller; strobes are single-cycle, payload holds when idle.
  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q      <= PW'(NUM_PORTS - 1);
      usr_addr_q    <= '0;
      usr_wr_data_q <= '0;
      usr_wr_be_q   <= '0;
      usr_wr_strb_q <= 1'b0;
      usr_rd_strb_q <= 1'b0;
    end else begin
      usr_wr_strb_q <= 1'b0;
      usr_rd_strb_q <= 1'b0;
      if (gnt_vld) begin
        rr_ptr_q      <= gnt_idx;
        usr_addr_q    <= sel_addr;
        usr_wr_strb_q <= gnt_wr;
        usr_rd_strb_q <= ~gnt_wr;
        if (gnt_wr) begin
          usr_wr_data_q <= sel_data;
          usr_wr_be_q   <= sel_be;
        end
      end
    end
  end

  // Tag FIFO holding the issuing port of each outstanding read.
  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < TAG_DEPTH; i++) tag_mem_q[i] <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        tag_mem_q[wptr_q] <= gnt_idx;
        wptr_q            <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Read return steering and sticky error flags.
  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) begin
      p_rd_data_q    <= '0;
      p_rd_dvld_q    <= '0;
      err_unexp_rd_q <= 1'b0;
      err_flush_q    <= 1'b0;
    end else begin
      p_rd_dvld_q <= '0;
      if (pop) begin
        p_rd_dvld_q[tag_mem_q[rptr_q]] <= 1'b1;
        p_rd_data_q                    <= usr_rd_data;
      end
      err_unexp_rd_q <= err_unexp_rd_q | (usr_rd_dvld & fifo_empty);
      err_flush_q    <= err_flush_q | flush;
    end
  end

`ifdef QDR_MPORT_STATS_EN
  logic [NUM_PORTS*32-1:0] stat_wr_q, stat_rd_q;

  // Per-port grant counters; a clear beats a same-cycle increment.
  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) begin
      stat_wr_q <= '0;
      stat_rd_q <= '0;
    end else if (stat_clr) begin
      stat_wr_q <= '0;
      stat_rd_q <= '0;
    end else if (gnt_vld) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (gnt_idx == PW'(i)) begin
          if (gnt_wr) stat_wr_q[i*32 +: 32] <= stat_wr_q[i*32 +: 32] + 32'd1;
          else        stat_rd_q[i*32 +: 32] <= stat_rd_q[i*32 +: 32] + 32'd1;
        end
      end
    end
  end

  assign stat_wr_cnt = stat_wr_q;
  assign stat_rd_cnt = stat_rd_q;
`endif

  assign usr_addr     = usr_addr_q;
  assign usr_wr_strb  = usr_wr_strb_q;
  assign usr_wr_data  = usr_wr_data_q;
  assign usr_wr_be    = usr_wr_be_q;
  assign usr_rd_strb  = usr_rd_strb_q;
  assign p_rd_data    = p_rd_data_q;
  assign p_rd_dvld    = p_rd_dvld_q;
  assign err_unexp_rd = err_unexp_rd_q;
  assign err_flush    = err_flush_q;

endmodule

// File: tb/tb_qdr_mport_arbiter.sv
// Directed bench for qdr_mport_arbiter: grant, ordering, tag-full, drain/flush, stray read, wr+rd priority.
// Inputs driven on the falling edge, outputs sampled 1 time unit later.
// Stat counters checked only when QDR_MPORT_STATS_EN is defined.
module tb_qdr_mport_arbiter;
  localparam int NP = 2;
  localparam int AW = 21;
  localparam int DW = 72;
  localparam int BW = 8;

  logic             clk0 = 1'b0;
  logic             reset_n;
  logic             phy_rdy;
  logic [NP*AW-1:0] p_addr;
  logic [NP-1:0]    p_wr_req, p_rd_req;
  logic [NP*DW-1:0] p_wr_data;
  logic [NP*BW-1:0] p_wr_be;
  logic [NP-1:0]    p_ack;
  logic             p_ack_wr;
  logic [DW-1:0]    p_rd_data;
  logic [NP-1:0]    p_rd_dvld;
  logic [AW-1:0]    usr_addr;
  logic             usr_wr_strb, usr_rd_strb;
  logic [DW-1:0]    usr_wr_data, usr_rd_data;
  logic [BW-1:0]    usr_wr_be;
  logic             usr_rd_dvld;
  logic             err_unexp_rd, err_flush;
`ifdef QDR_MPORT_STATS_EN
  logic             stat_clr;
  logic [NP*32-1:0] stat_wr_cnt, stat_rd_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk0 = ~clk0;

  qdr_mport_arbiter #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW),
    .TAG_DEPTH(16), .DRAIN_CYCLES(64)
  ) dut (
    .clk0(clk0), .reset_n(reset_n), .phy_rdy(phy_rdy),
    .p_addr(p_addr), .p_wr_req(p_wr_req), .p_rd_req(p_rd_req),
    .p_wr_data(p_wr_data), .p_wr_be(p_wr_be),
    .p_ack(p_ack), .p_ack_wr(p_ack_wr), .p_rd_data(p_rd_data), .p_rd_dvld(p_rd_dvld),
    .usr_addr(usr_addr), .usr_wr_strb(usr_wr_strb), .usr_wr_data(usr_wr_data),
    .usr_wr_be(usr_wr_be), .usr_rd_strb(usr_rd_strb), .usr_rd_data(usr_rd_data),
    .usr_rd_dvld(usr_rd_dvld), .err_unexp_rd(err_unexp_rd),
`ifdef QDR_MPORT_STATS_EN
    .stat_clr(stat_clr), .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt),
`endif
    .err_flush(err_flush)
  );

  task automatic drive_idle();
    phy_rdy = 1'b0; p_addr = '0; p_wr_req = '0; p_rd_req = '0;
    p_wr_data = '0; p_wr_be = '0; usr_rd_data = '0; usr_rd_dvld = 1'b0;
`ifdef QDR_MPORT_STATS_EN
    stat_clr = 1'b0;
`endif
  endtask

  // Reset, raise phy_rdy, return at the falling edge where the DUT is in RUN.
  task automatic do_reset_run();
    @(negedge clk0);
    reset_n = 1'b0;
    drive_idle();
    @(negedge clk0);
    @(negedge clk0);
    reset_n = 1'b1;
    phy_rdy = 1'b1;
    @(negedge clk0);
  endtask

  task automatic test_reset();
    @(negedge clk0);
    reset_n = 1'b0;
    drive_idle();
    phy_rdy = 1'b1; p_wr_req = 2'b11; p_rd_req = 2'b11;
    #1;
    n_cmp++; if ({p_ack, p_ack_wr, p_rd_dvld} !== 5'b0) begin n_bad++; $display("FAIL rst_ack: got %b want 0", {p_ack, p_ack_wr, p_rd_dvld}); end
    n_cmp++; if ({usr_wr_strb, usr_rd_strb, err_unexp_rd, err_flush} !== 4'b0) begin n_bad++; $display("FAIL rst_flags: got %b want 0", {usr_wr_strb, usr_rd_strb, err_unexp_rd, err_flush}); end
    n_cmp++; if ({usr_addr, usr_wr_data, usr_wr_be, p_rd_data} !== '0) begin n_bad++; $display("FAIL rst_data: got %h want 0", {usr_addr, usr_wr_data, usr_wr_be, p_rd_data}); end
    // Reset asserted between a grant and its clock edge: no strobe may follow.
    do_reset_run();
    p_addr[AW-1:0] = 21'h00123; p_wr_req = 2'b01;
    #1;
    n_cmp++; if (p_ack !== 2'b01) begin n_bad++; $display("FAIL rstmid_ack: got %b want 01", p_ack); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (p_ack !== 2'b00) begin n_bad++; $display("FAIL rstmid_ack_clr: got %b want 00", p_ack); end
    @(negedge clk0);
    #1;
    n_cmp++; if ({usr_wr_strb, usr_addr} !== '0) begin n_bad++; $display("FAIL rstmid_strb: got %h want 0", {usr_wr_strb, usr_addr}); end
    reset_n = 1'b1;
    drive_idle();
  endtask

  task automatic test_single_write();
    do_reset_run();
    p_addr[AW-1:0] = 21'h00010; p_wr_data[DW-1:0] = {9{8'hA5}}; p_wr_be[BW-1:0] = 8'hFF;
    p_wr_req = 2'b01;
    #1;
    n_cmp++; if ({p_ack, p_ack_wr} !== 3'b011) begin n_bad++; $display("FAIL sw_ack: got %b want 011", {p_ack, p_ack_wr}); end
    @(negedge clk0);
    p_wr_req = 2'b00;
    #1;
    n_cmp++; if ({usr_wr_strb, usr_rd_strb} !== 2'b10) begin n_bad++; $display("FAIL sw_strb: got %b want 10", {usr_wr_strb, usr_rd_strb}); end
    n_cmp++; if (usr_addr !== 21'h00010) begin n_bad++; $display("FAIL sw_addr: got %h want 00010", usr_addr); end
    n_cmp++; if ({usr_wr_data, usr_wr_be} !== {{9{8'hA5}}, 8'hFF}) begin n_bad++; $display("FAIL sw_data: got %h/%h want a5../ff", usr_wr_data, usr_wr_be); end
    @(negedge clk0);
    #1;
    n_cmp++; if ({usr_wr_strb, usr_addr} !== {1'b0, 21'h00010}) begin n_bad++; $display("FAIL sw_pulse_hold: got %b/%h want 0/00010", usr_wr_strb, usr_addr); end
  endtask

  // Both ports read for 8 cycles; controller model answers each strobe 10 cycles later with the address as data.
  task automatic test_contention();
    bit            seen [24];
    logic [AW-1:0] saddr [24];
    bit            drv_prev;
    int            ret, nstrb, port;
    logic [1:0]    exp_ack;
    logic [DW-1:0] exp_dat;
    do_reset_run();
    p_addr = {21'h00200, 21'h00100};
    p_rd_req = 2'b11;
    drv_prev = 1'b0; ret = 0; nstrb = 0;
    for (int n = 0; n < 24; n++) begin
      if (n == 8) p_rd_req = 2'b00;
      usr_rd_dvld = 1'b0;
      if (n >= 10 && seen[n-10]) begin
        usr_rd_dvld = 1'b1;
        usr_rd_data = {51'd0, saddr[n-10]};
      end
      #1;
      if (n < 8) begin
        exp_ack = (n % 2 == 0) ? 2'b01 : 2'b10;
        n_cmp++; if ({p_ack, p_ack_wr} !== {exp_ack, 1'b0}) begin n_bad++; $display("FAIL rr_ack[%0d]: got %b want %b0", n, {p_ack, p_ack_wr}, exp_ack); end
      end
      if (drv_prev) begin
        port    = ret % 2;
        exp_ack = (port == 0) ? 2'b01 : 2'b10;
        exp_dat = (port == 0) ? 72'h100 : 72'h200;
        n_cmp++; if ({p_rd_dvld, p_rd_data} !== {exp_ack, exp_dat}) begin n_bad++; $display("FAIL rr_ret[%0d]: got %b/%h want %b/%h", ret, p_rd_dvld, p_rd_data, exp_ack, exp_dat); end
        ret++;
      end
      seen[n]  = usr_rd_strb;
      saddr[n] = usr_addr;
      if (usr_rd_strb) nstrb++;
      drv_prev = usr_rd_dvld;
      @(negedge clk0);
    end
    n_cmp++; if (nstrb != 8) begin n_bad++; $display("FAIL rr_strb_cnt: got %0d want 8", nstrb); end
    n_cmp++; if (err_unexp_rd !== 1'b0) begin n_bad++; $display("FAIL rr_no_stray: got %b want 0", err_unexp_rd); end
  endtask

  task automatic test_tag_full();
    int acks;
    do_reset_run();
    p_addr = {21'h00300, 21'h00040};
    p_rd_req = 2'b01;
    acks = 0;
    for (int n = 0; n < 16; n++) begin
      #1;
      if (p_ack == 2'b01) acks++;
      @(negedge clk0);
    end
    n_cmp++; if (acks != 16) begin n_bad++; $display("FAIL full_acks: got %0d want 16", acks); end
    #1;
    n_cmp++; if (p_ack !== 2'b00) begin n_bad++; $display("FAIL full_block: got %b want 00", p_ack); end
    @(negedge clk0);
    p_wr_req = 2'b10;
    #1;
    n_cmp++; if ({p_ack, p_ack_wr} !== 3'b101) begin n_bad++; $display("FAIL full_wr_ok: got %b want 101", {p_ack, p_ack_wr}); end
    @(negedge clk0);
    p_wr_req = 2'b00; usr_rd_dvld = 1'b1; usr_rd_data = 72'h123;
    #1;
    n_cmp++; if (p_ack !== 2'b00) begin n_bad++; $display("FAIL full_pop_same: got %b want 00", p_ack); end
    @(negedge clk0);
    usr_rd_dvld = 1'b0;
    #1;
    n_cmp++; if (p_ack !== 2'b01) begin n_bad++; $display("FAIL full_after_pop: got %b want 01", p_ack); end
    n_cmp++; if ({p_rd_dvld, p_rd_data} !== {2'b01, 72'h123}) begin n_bad++; $display("FAIL full_ret: got %b/%h want 01/123", p_rd_dvld, p_rd_data); end
    @(negedge clk0);
    p_rd_req = 2'b00;
  endtask

  task automatic test_drain();
    logic [DW-1:0] d;
    do_reset_run();
    p_addr[AW-1:0] = 21'h00050;
    p_rd_req = 2'b01;
    for (int n = 0; n < 3; n++) begin
      #1;
      n_cmp++; if (p_ack !== 2'b01) begin n_bad++; $display("FAIL dr_issue[%0d]: got %b want 01", n, p_ack); end
      @(negedge clk0);
    end
    p_rd_req = 2'b10; phy_rdy = 1'b0;
    #1;
    n_cmp++; if (p_ack !== 2'b00) begin n_bad++; $display("FAIL dr_phy_low: got %b want 00", p_ack); end
    for (int n = 0; n < 4; n++) begin
      @(negedge clk0);
      usr_rd_dvld = (n < 3);
      usr_rd_data = 72'hD0 + DW'(n);
      if (n == 3) phy_rdy = 1'b1;
      #1;
      n_cmp++; if (p_ack !== 2'b00) begin n_bad++; $display("FAIL dr_nogrant[%0d]: got %b want 00", n, p_ack); end
      if (n > 0) begin
        d = 72'hD0 + DW'(n - 1);
        n_cmp++; if ({p_rd_dvld, p_rd_data} !== {2'b01, d}) begin n_bad++; $display("FAIL dr_ret[%0d]: got %b/%h want 01/%h", n - 1, p_rd_dvld, p_rd_data, d); end
      end
    end
    @(negedge clk0);
    #1;
    n_cmp++; if (p_ack !== 2'b00) begin n_bad++; $display("FAIL dr_wait_phy: got %b want 00", p_ack); end
    @(negedge clk0);
    #1;
    n_cmp++; if (p_ack !== 2'b10) begin n_bad++; $display("FAIL dr_resume: got %b want 10", p_ack); end
    n_cmp++; if (err_flush !== 1'b0) begin n_bad++; $display("FAIL dr_no_flush: got %b want 0", err_flush); end
    @(negedge clk0);
    p_rd_req = 2'b00;
  endtask

  task automatic test_flush_timeout();
    do_reset_run();
    p_rd_req = 2'b01;
    repeat (3) @(negedge clk0);
    p_rd_req = 2'b00; phy_rdy = 1'b0;
    for (int k = 1; k <= 65; k++) @(negedge clk0);
    #1;
    n_cmp++; if (err_flush !== 1'b0) begin n_bad++; $display("FAIL fl_early: got %b want 0", err_flush); end
    @(negedge clk0);
    #1;
    n_cmp++; if (err_flush !== 1'b1) begin n_bad++; $display("FAIL fl_set: got %b want 1", err_flush); end
    usr_rd_dvld = 1'b1; usr_rd_data = 72'hBAD;
    @(negedge clk0);
    usr_rd_dvld = 1'b0;
    #1;
    n_cmp++; if ({p_rd_dvld, err_unexp_rd, err_flush} !== 4'b0011) begin n_bad++; $display("FAIL fl_fifo_empty: got %b want 0011", {p_rd_dvld, err_unexp_rd, err_flush}); end
  endtask

  task automatic test_stray_read();
    do_reset_run();
    #1;
    n_cmp++; if (err_unexp_rd !== 1'b0) begin n_bad++; $display("FAIL st_init: got %b want 0", err_unexp_rd); end
    usr_rd_dvld = 1'b1; usr_rd_data = 72'h777;
    @(negedge clk0);
    usr_rd_dvld = 1'b0;
    #1;
    n_cmp++; if ({p_rd_dvld, err_unexp_rd} !== 3'b001) begin n_bad++; $display("FAIL st_flag: got %b want 001", {p_rd_dvld, err_unexp_rd}); end
    repeat (5) @(negedge clk0);
    #1;
    n_cmp++; if (err_unexp_rd !== 1'b1) begin n_bad++; $display("FAIL st_sticky: got %b want 1", err_unexp_rd); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (err_unexp_rd !== 1'b0) begin n_bad++; $display("FAIL st_rst_clr: got %b want 0", err_unexp_rd); end
    reset_n = 1'b1;
  endtask

  task automatic test_wr_rd_same_port();
    do_reset_run();
    p_addr[AW-1:0] = 21'h00077; p_wr_data[DW-1:0] = {9{8'h55}}; p_wr_be[BW-1:0] = 8'h0F;
    p_wr_req = 2'b01; p_rd_req = 2'b01;
    #1;
    n_cmp++; if ({p_ack, p_ack_wr} !== 3'b011) begin n_bad++; $display("FAIL wr_first: got %b want 011", {p_ack, p_ack_wr}); end
    @(negedge clk0);
    p_wr_req = 2'b00;
    #1;
    n_cmp++; if ({p_ack, p_ack_wr} !== 3'b010) begin n_bad++; $display("FAIL rd_second: got %b want 010", {p_ack, p_ack_wr}); end
    n_cmp++; if ({usr_wr_strb, usr_wr_be} !== {1'b1, 8'h0F}) begin n_bad++; $display("FAIL wrrd_wstrb: got %b/%h want 1/0f", usr_wr_strb, usr_wr_be); end
    @(negedge clk0);
    p_rd_req = 2'b00;
    #1;
    n_cmp++; if ({usr_rd_strb, usr_wr_strb, usr_addr} !== {2'b10, 21'h00077}) begin n_bad++; $display("FAIL wrrd_rstrb: got %b%b/%h want 10/00077", usr_rd_strb, usr_wr_strb, usr_addr); end
`ifdef QDR_MPORT_STATS_EN
    n_cmp++; if ({stat_wr_cnt, stat_rd_cnt} !== {32'd0, 32'd1, 32'd0, 32'd1}) begin n_bad++; $display("FAIL stat_cnt: got %h/%h want 0..1/0..1", stat_wr_cnt, stat_rd_cnt); end
    stat_clr = 1'b1; p_wr_req = 2'b10;
    @(negedge clk0);
    stat_clr = 1'b0; p_wr_req = 2'b00;
    #1;
    n_cmp++; if ({stat_wr_cnt, stat_rd_cnt} !== '0) begin n_bad++; $display("FAIL stat_clr_prio: got %h/%h want 0/0", stat_wr_cnt, stat_rd_cnt); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    drive_idle();
    test_reset();
    test_single_write();
    test_contention();
    test_tag_full();
    test_drain();
    test_flush_timeout();
    test_stray_read();
    test_wr_rd_same_port();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
